// File: rtl/udp_chan_reader.sv
// UDP channel-word reader: frames of <channel id, CAPACITY payload bytes> update one
// channel word, fire a trigger on an all-0xFF payload, or are rejected and counted.
module udp_chan_reader #(
    parameter int unsigned CAPACITY = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CHK_LEN  = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           valid,
    input  logic                           rx_end,
    input  logic [7:0]                     i_data,
    input  logic [15:0]                    i_len,
    output logic [CHANNELS*CAPACITY*8-1:0] o_data,
    output logic [CHANNELS-1:0]            o_upd,
    output logic                           error,
    output logic                           trig,
    output logic [7:0]                     trig_ch,
    output logic [7:0]                     err_cnt
);

    localparam int unsigned WORD_W    = CAPACITY * 8;
    localparam int unsigned FRAME_LEN = CAPACITY + 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt, cnt_eff;
    logic [WORD_W-1:0] stage, stage_nxt, stage_eff;
    logic [7:0]        id, id_nxt, id_eff;
    logic              frame_done, frame_ok, all_ff, all_zero;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; the byte of this cycle is folded in before an rx_end evaluates the frame
    always_comb begin
        state_nxt  = state;
        cnt_eff    = cnt;
        stage_eff  = stage;
        id_eff     = id;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        all_ff     = 1'b0;
        all_zero   = 1'b0;

        if (valid) begin
            cnt_eff = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            if (state != DROP) begin
                if (cnt == 16'd0) id_eff = i_data;
                for (int i = 1; i <= int'(CAPACITY); i++) begin
                    if (cnt == 16'(i)) stage_eff[(int'(CAPACITY) - i) * 8 +: 8] = i_data;
                end
            end
        end

        case (state)
            IDLE:    if (valid) state_nxt = RECV;
            RECV:    if (valid && cnt >= 16'(FRAME_LEN)) state_nxt = DROP;
            default: state_nxt = state;
        endcase

        cnt_nxt   = cnt_eff;
        stage_nxt = stage_eff;
        id_nxt    = id_eff;

        if (rx_end) begin
            frame_done = 1'b1;
            frame_ok   = (cnt_eff == 16'(FRAME_LEN))
                       && ((CHK_LEN == 0) || (cnt_eff == i_len))
                       && ({1'b0, id_eff} < 9'(CHANNELS));
            all_ff     = (stage_eff == '1);
            all_zero   = (stage_eff == '0);
            state_nxt  = IDLE;
            cnt_nxt    = 16'd0;
            stage_nxt  = '0;
            id_nxt     = 8'd0;
        end
    end

    // Frame assembly registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= 16'd0;
            stage <= '0;
            id    <= 8'd0;
        end else begin
            cnt   <= cnt_nxt;
            stage <= stage_nxt;
            id    <= id_nxt;
        end
    end

    // Frame results, registered on the rx_end edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_data  <= '0;
            o_upd   <= '0;
            error   <= 1'b0;
            trig    <= 1'b0;
            trig_ch <= 8'd0;
            err_cnt <= 8'd0;
        end else begin
            o_upd <= '0;
            trig  <= 1'b0;
            if (frame_done) begin
                if (!frame_ok) begin
                    error <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end else begin
                    error <= 1'b0;
                    if (all_ff) begin
                        trig    <= 1'b1;
                        trig_ch <= id_eff;
                    end else if (!all_zero) begin
                        for (int k = 0; k < int'(CHANNELS); k++) begin
                            if (id_eff == 8'(k)) begin
                                o_data[k * int'(WORD_W) +: WORD_W] <= stage_eff;
                                o_upd[k] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_chan_reader.sv
// Directed bench for udp_chan_reader (CAPACITY=4, CHANNELS=2, CHK_LEN=1).
module tb_udp_chan_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        rx_end;
    logic [7:0]  i_data;
    logic [15:0] i_len;
    logic [63:0] o_data;
    logic [1:0]  o_upd;
    logic        error;
    logic        trig;
    logic [7:0]  trig_ch;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    udp_chan_reader #(.CAPACITY(4), .CHANNELS(2), .CHK_LEN(1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid   (valid),
        .rx_end  (rx_end),
        .i_data  (i_data),
        .i_len   (i_len),
        .o_data  (o_data),
        .o_upd   (o_upd),
        .error   (error),
        .trig    (trig),
        .trig_ch (trig_ch),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, return 1ns after the rising edge
    task automatic cyc(input logic v, input logic e, input logic [7:0] d);
        @(negedge clk);
        valid  = v;
        rx_end = e;
        i_data = d;
        @(posedge clk);
        #1;
    endtask

    // Bytes are taken MSB-first from b; merged puts rx_end on the last byte
    task automatic frame(input int n, input logic [63:0] b, input logic merged);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, merged && (k == n - 1), b[63 - 8 * k -: 8]);
        end
        if (!merged) cyc(1'b0, 1'b1, 8'h00);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rstn   = 1'b0;
        valid  = 1'b0;
        rx_end = 1'b0;
        i_data = 8'h00;
        i_len  = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_data",  o_data, 64'h0);
        chk("rst_o_upd",   64'(o_upd), 64'h0);
        chk("rst_error",   64'(error), 64'h0);
        chk("rst_trig",    64'(trig), 64'h0);
        chk("rst_trig_ch", 64'(trig_ch), 64'h0);
        chk("rst_err_cnt", 64'(err_cnt), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Channel 1 update
        frame(5, 64'h01_12345678_000000, 1'b0);
        chk("ch1_o_data", o_data, 64'h12345678_00000000);
        chk("ch1_o_upd",  64'(o_upd), 64'h2);
        chk("ch1_error",  64'(error), 64'h0);
        chk("ch1_trig",   64'(trig), 64'h0);
        idle();
        chk("ch1_upd_pulse", 64'(o_upd), 64'h0);

        // All-0xFF command on channel 0
        frame(5, 64'h00_FFFFFFFF_000000, 1'b0);
        chk("trig0_trig",    64'(trig), 64'h1);
        chk("trig0_trig_ch", 64'(trig_ch), 64'h0);
        chk("trig0_o_data",  o_data, 64'h12345678_00000000);
        chk("trig0_o_upd",   64'(o_upd), 64'h0);
        idle();
        chk("trig0_pulse", 64'(trig), 64'h0);

        // All-0xFF command on channel 1; trig_ch holds afterwards
        frame(5, 64'h01_FFFFFFFF_000000, 1'b0);
        chk("trig1_trig",    64'(trig), 64'h1);
        chk("trig1_trig_ch", 64'(trig_ch), 64'h1);
        idle();
        chk("trig1_hold_ch", 64'(trig_ch), 64'h1);

        // Short frame
        i_len = 16'd4;
        frame(4, 64'h00_AABBCC_00000000, 1'b0);
        chk("short_error",   64'(error), 64'h1);
        chk("short_err_cnt", 64'(err_cnt), 64'h1);
        chk("short_o_data",  o_data, 64'h12345678_00000000);
        chk("short_o_upd",   64'(o_upd), 64'h0);

        // Last byte and rx_end in the same cycle, channel 0
        i_len = 16'd5;
        frame(5, 64'h00_12345678_000000, 1'b1);
        chk("merged_o_data",  o_data, 64'h12345678_12345678);
        chk("merged_o_upd",   64'(o_upd), 64'h1);
        chk("merged_error",   64'(error), 64'h0);
        chk("merged_err_cnt", 64'(err_cnt), 64'h1);

        // Channel id out of range
        frame(5, 64'h02_11223344_000000, 1'b0);
        chk("badch_error",   64'(error), 64'h1);
        chk("badch_err_cnt", 64'(err_cnt), 64'h2);
        chk("badch_o_upd",   64'(o_upd), 64'h0);

        // Over-long frame goes through DROP
        i_len = 16'd7;
        frame(7, 64'h00_112233445566_00, 1'b0);
        chk("long_error",   64'(error), 64'h1);
        chk("long_err_cnt", 64'(err_cnt), 64'h3);
        chk("long_o_data",  o_data, 64'h12345678_12345678);

        // Correct shape but i_len disagrees
        i_len = 16'd6;
        frame(5, 64'h01_01020304_000000, 1'b0);
        chk("len_error",   64'(error), 64'h1);
        chk("len_err_cnt", 64'(err_cnt), 64'h4);
        chk("len_o_data",  o_data, 64'h12345678_12345678);

        // Good frame after the error, then an all-zero payload
        i_len = 16'd5;
        frame(5, 64'h01_0A0B0C0D_000000, 1'b0);
        chk("good_o_data", o_data, 64'h0A0B0C0D_12345678);
        chk("good_error",  64'(error), 64'h0);
        frame(5, 64'h01_00000000_000000, 1'b0);
        chk("zero_error",  64'(error), 64'h0);
        chk("zero_o_data", o_data, 64'h0A0B0C0D_12345678);
        chk("zero_o_upd",  64'(o_upd), 64'h0);
        chk("zero_trig",   64'(trig), 64'h0);

        // rx_end with no bytes
        cyc(1'b0, 1'b1, 8'h00);
        chk("empty_error",   64'(error), 64'h1);
        chk("empty_err_cnt", 64'(err_cnt), 64'h5);

        // Error counter saturation
        for (int n = 0; n < 250; n++) cyc(1'b0, 1'b1, 8'h00);
        chk("sat_reach", 64'(err_cnt), 64'hFF);
        for (int n = 0; n < 6; n++) cyc(1'b0, 1'b1, 8'h00);
        chk("sat_hold", 64'(err_cnt), 64'hFF);
        idle();

        // Reset mid-frame, then a full frame
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        @(negedge clk);
        valid = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("arst_o_data",  o_data, 64'h0);
        chk("arst_err_cnt", 64'(err_cnt), 64'h0);
        chk("arst_trig_ch", 64'(trig_ch), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        frame(5, 64'h00_01020304_000000, 1'b0);
        chk("post_rst_o_data", o_data, 64'h00000000_01020304);
        chk("post_rst_o_upd",  64'(o_upd), 64'h1);
        chk("post_rst_error",  64'(error), 64'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
